inst_queue: RTL and testbench
=============================

// Module: inst_queue
// PURPOSE
//  Decoupling FIFO between the fetch stage and the decode stage.
//  - Accepts {inst, pc} packets from IF through the valid/allowin handshake.
//  - Presents them to ID in first-word-fall-through order.
//  - A pipeline flush discards all buffered wrong-path instructions.
//  - Hides single-cycle ID stalls so that IF keeps fetching.
// PARAMETERS
//  DEPTH    4   entry count; power of two, >= 2
//  BUS_WD   64  packet width, {inst[63:32], pc[31:0]} (= FS_TO_DS_BUS_WD)
// PORTS
//  clk             in   1       clock; all state updates on posedge
//  resetn          in   1       asynchronous, active-low reset
//  fs_to_ds_valid  in   1       IF presents a valid packet
//  fs_to_ds_bus    in   BUS_WD  packet from IF
//  ds_allowin      out  1       queue can accept a packet this cycle (to IF)
//  flush           in   1       discard all contents (branch taken / redirect)
//  iq_to_ds_valid  out  1       head entry valid (to ID)
//  iq_to_ds_bus    out  BUS_WD  head entry packet (to ID)
//  ds_ready        in   1       ID consumes the head this cycle
//  iq_count        out  log2(DEPTH)+1  number of occupied entries
// BEHAVIOUR
//  - State:
//    - buf[DEPTH] of BUS_WD bits
//    - rd_ptr, wr_ptr: log2(DEPTH) bits each, wrap modulo DEPTH naturally
//    - count: log2(DEPTH)+1 bits
//  - Reset (resetn=0, async):
//    - rd_ptr, wr_ptr and count go to 0; buf contents are don't-care.
//    - Outputs: ds_allowin=1, iq_to_ds_valid=0, iq_to_ds_bus=0, iq_count=0.
//  - Combinational outputs:
//    - ds_allowin     = (count != DEPTH). No pass-through when full, even if
//      a pop occurs in the same cycle. This keeps the path ds_ready->allowin
//      free of logic.
//    - iq_to_ds_valid = (count != 0)
//    - iq_to_ds_bus   = count!=0 ? buf[rd_ptr] : 0
//    - iq_count       = count
//  - Events per cycle:
//    - push = fs_to_ds_valid & ds_allowin & ~flush
//    - pop  = iq_to_ds_valid & ds_ready
//  - Sequential update, on the rising edge, when flush=0:
//    - push: buf[wr_ptr] <= fs_to_ds_bus; wr_ptr <= wr_ptr+1
//    - pop:  rd_ptr <= rd_ptr+1
//    - count <= count + push - pop; push and pop together leave count unchanged.
//  - Latency:
//    - A packet pushed at edge N is visible on iq_to_ds_* in the cycle
//      after edge N (one cycle, no bypass when empty).
//    - Throughput is 1 packet/cycle with simultaneous push and pop.
//  - Flush (synchronous, highest priority):
//    - Next edge: rd_ptr=wr_ptr=count=0.
//    - A push offered in the flush cycle is dropped; IF re-fetches from the
//      target.
//    - A pop in the flush cycle is still a legal ID handshake (the head is
//      consumed by ID), but it has no further effect on queue state.
//  - Boundaries:
//    - Empty: pop is impossible, so ds_ready is ignored.
//    - Full: push is impossible, so fs_to_ds_valid is ignored.
//    - Pointer wrap from DEPTH-1 to 0 is seamless; FIFO order is preserved
//      across the wrap.
//    - Reset asserted mid-operation empties the queue immediately
//      (asynchronously).
//  - Invariants:
//    - count never exceeds DEPTH and never underflows.
//    - wr_ptr - rd_ptr == count mod DEPTH.
// TESTING
//  1. Reset:
//     - Stimulus: assert resetn=0 mid-stream with 2 entries buffered.
//     - Required: iq_to_ds_valid=0, iq_count=0 and ds_allowin=1 immediately,
//       before any clock edge.
//  2. Fill to full:
//     - Stimulus: ds_ready=0; push pc 0x1c000000, 0x1c000004, 0x1c000008,
//       0x1c00000c.
//     - Required: iq_count=4, ds_allowin=0; a 5th push is ignored;
//       head pc=0x1c000000.
//  3. Streaming:
//     - Stimulus: fs_to_ds_valid=1 and ds_ready=1 every cycle for 10 packets.
//     - Required: iq_count stays at 1 after the first edge; ID receives
//       pcs in order with no bubbles.
//  4. Wrap-around:
//     - Stimulus: 7 pushes interleaved with 5 pops (pointers wrap past 3).
//     - Required: output order matches input order; iq_count=2 at the end.
//  5. Flush:
//     - Stimulus: 3 entries buffered, flush=1 together with a push of
//       pc 0x1c000100.
//     - Required: next cycle iq_count=0, iq_to_ds_valid=0, and
//       0x1c000100 never appears at the output.
//  6. Full with pop:
//     - Stimulus: queue full, ds_ready=1, fs_to_ds_valid=1.
//     - Required: ds_allowin=0 in that cycle; the next edge gives
//       iq_count=3; the following cycle accepts the push.

Source files
------------

// File: rtl/inst_queue_if.sv
// Fetch-to-decode queue port bundle: IF push side, ID pop side, flush and occupancy.
// master = pipeline side (drives IF packets, flush, ID ready); slave = the queue itself.
interface inst_queue_if #(
   parameter int DEPTH  = 4,
   parameter int BUS_WD = 64
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   // Handshake: a packet moves IF->queue on a cycle where fs_to_ds_valid & ds_allowin
   // (and no flush), and queue->ID on a cycle where iq_to_ds_valid & ds_ready; valid
   // and bus hold steady until the transfer; ready/allowin never depend on valid.
   logic              fs_to_ds_valid;
   logic [BUS_WD-1:0] fs_to_ds_bus;
   logic              ds_allowin;
   logic              flush;
   logic              iq_to_ds_valid;
   logic [BUS_WD-1:0] iq_to_ds_bus;
   logic              ds_ready;
   logic [CNT_W-1:0]  iq_count;

   modport master (
      output fs_to_ds_valid, fs_to_ds_bus, flush, ds_ready,
      input  ds_allowin, iq_to_ds_valid, iq_to_ds_bus, iq_count
   );

   modport slave (
      input  fs_to_ds_valid, fs_to_ds_bus, flush, ds_ready,
      output ds_allowin, iq_to_ds_valid, iq_to_ds_bus, iq_count
   );
endinterface

// File: rtl/inst_queue.sv
// First-word-fall-through instruction queue between IF and ID; flush discards
// every buffered wrong-path packet.
module inst_queue #(
   parameter int DEPTH  = 4,
   parameter int BUS_WD = 64
) (
   input  logic         clk,
   input  logic         resetn,
   inst_queue_if.slave  iq
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [BUS_WD-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic              push;
   logic              pop;

   // allowin looks only at count, so ds_ready never reaches the IF side.
   assign iq.ds_allowin     = (count != FULL_CNT);
   assign iq.iq_to_ds_valid = (count != '0);
   assign iq.iq_to_ds_bus   = (count != '0) ? mem[rd_ptr] : '0;
   assign iq.iq_count       = count;

   assign push = iq.fs_to_ds_valid & iq.ds_allowin & ~iq.flush;
   assign pop  = iq.iq_to_ds_valid & iq.ds_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (iq.flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= iq.fs_to_ds_bus;
   end

   a_count_bound: assert property (@(posedge clk) disable iff (!resetn)
      count <= FULL_CNT);

   a_ptr_count: assert property (@(posedge clk) disable iff (!resetn)
      (wr_ptr - rd_ptr) == count[PTR_W-1:0]);
endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: reset, fill, streaming, wrap, flush and full-with-pop.
module tb_inst_queue;
  localparam int DEPTH  = 4;
  localparam int BUS_WD = 64;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_pass;
  logic [BUS_WD-1:0] exp_q[$];

  inst_queue_if #(.DEPTH(DEPTH), .BUS_WD(BUS_WD)) iq_if ();

  inst_queue #(.DEPTH(DEPTH), .BUS_WD(BUS_WD)) dut (
    .clk    (clk),
    .resetn (resetn),
    .iq     (iq_if)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] pkt(input logic [31:0] pc);
    return {~pc, pc};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    iq_if.fs_to_ds_valid = v;
    iq_if.fs_to_ds_bus   = v ? pkt(pc) : '0;
    iq_if.ds_ready       = rdy;
    iq_if.flush          = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag);
    check({tag, "_valid"}, 64'(iq_if.iq_to_ds_valid), 64'd1);
    check({tag, "_bus"}, iq_if.iq_to_ds_bus, exp_q[0]);
    void'(exp_q.pop_front());
  endtask

  initial begin
    logic [31:0] pc;
    bit pv [9];
    bit rv [9];
    int np;
    n_checks = 0;
    n_pass   = 0;
    resetn   = 1'b0;
    drive(0, 32'h0, 0, 0);

    // reset state
    #12;
    check("rst_allowin", 64'(iq_if.ds_allowin), 64'd1);
    check("rst_valid", 64'(iq_if.iq_to_ds_valid), 64'd0);
    check("rst_bus", iq_if.iq_to_ds_bus, 64'd0);
    check("rst_count", 64'(iq_if.iq_count), 64'd0);
    resetn = 1'b1;
    tick;

    // fill to full, 5th push ignored, drain in order
    for (int i = 0; i < 4; i++) begin
      pc = 32'h1c000000 + 32'(i * 4);
      drive(1, pc, 0, 0);
      tick;
    end
    check("full_count", 64'(iq_if.iq_count), 64'd4);
    check("full_allowin", 64'(iq_if.ds_allowin), 64'd0);
    check("full_head", iq_if.iq_to_ds_bus, pkt(32'h1c000000));
    drive(1, 32'h1c000010, 0, 0);
    tick;
    check("full_5th_count", 64'(iq_if.iq_count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(pkt(32'h1c000000 + 32'(i * 4)));
    end
    for (int i = 0; i < 4; i++) begin
      check_head("fill_drain");
      drive(0, 32'h0, 1, 0);
      tick;
    end
    check("fill_empty_valid", 64'(iq_if.iq_to_ds_valid), 64'd0);
    check("fill_empty_count", 64'(iq_if.iq_count), 64'd0);

    // asynchronous reset with two entries buffered
    drive(1, 32'h1c000020, 0, 0);
    tick;
    drive(1, 32'h1c000024, 0, 0);
    tick;
    drive(0, 32'h0, 0, 0);
    check("pre_rst_count", 64'(iq_if.iq_count), 64'd2);
    #3 resetn = 1'b0;
    #1;
    check("async_rst_valid", 64'(iq_if.iq_to_ds_valid), 64'd0);
    check("async_rst_count", 64'(iq_if.iq_count), 64'd0);
    check("async_rst_allowin", 64'(iq_if.ds_allowin), 64'd1);
    check("async_rst_bus", iq_if.iq_to_ds_bus, 64'd0);
    #2 resetn = 1'b1;
    tick;

    // streaming: push and pop every cycle, count holds at 1
    pc = 32'h1c000040;
    drive(1, pc, 1, 0);
    exp_q.push_back(pkt(pc));
    tick;
    for (int i = 1; i < 10; i++) begin
      check("stream_count", 64'(iq_if.iq_count), 64'd1);
      check_head("stream");
      pc = 32'h1c000040 + 32'(i * 4);
      drive(1, pc, 1, 0);
      exp_q.push_back(pkt(pc));
      tick;
    end
    check("stream_last_count", 64'(iq_if.iq_count), 64'd1);
    check_head("stream_last");
    drive(0, 32'h0, 1, 0);
    tick;
    check("stream_end_count", 64'(iq_if.iq_count), 64'd0);

    // wrap-around: 7 pushes interleaved with 5 pops, pointers start at 2
    pv = '{1, 1, 1, 1, 0, 1, 1, 0, 1};
    rv = '{0, 0, 1, 0, 1, 1, 0, 1, 1};
    np = 0;
    for (int k = 0; k < 9; k++) begin
      if (rv[k]) check_head("wrap");
      pc = 32'h0;
      if (pv[k]) begin
        pc = 32'h1c000200 + 32'(np * 4);
        exp_q.push_back(pkt(pc));
        np++;
      end
      drive(pv[k], pc, rv[k], 0);
      tick;
    end
    check("wrap_count", 64'(iq_if.iq_count), 64'd2);
    for (int i = 0; i < 2; i++) begin
      check_head("wrap_drain");
      drive(0, 32'h0, 1, 0);
      tick;
    end
    check("wrap_empty_count", 64'(iq_if.iq_count), 64'd0);

    // flush with a simultaneous push (and pop) drops everything
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h1c000300 + 32'(i * 4), 0, 0);
      tick;
    end
    check("preflush_count", 64'(iq_if.iq_count), 64'd3);
    drive(1, 32'h1c000100, 1, 1);
    tick;
    check("flush_count", 64'(iq_if.iq_count), 64'd0);
    check("flush_valid", 64'(iq_if.iq_to_ds_valid), 64'd0);
    check("flush_bus", iq_if.iq_to_ds_bus, 64'd0);
    drive(0, 32'h0, 1, 0);
    tick;
    check("postflush_valid", 64'(iq_if.iq_to_ds_valid), 64'd0);
    check("postflush_count", 64'(iq_if.iq_count), 64'd0);

    // full with pop: no pass-through, push accepted the cycle after
    for (int i = 0; i < 4; i++) begin
      pc = 32'h1c000400 + 32'(i * 4);
      exp_q.push_back(pkt(pc));
      drive(1, pc, 0, 0);
      tick;
    end
    drive(1, 32'h1c000410, 1, 0);
    #1;
    check("fullpop_allowin", 64'(iq_if.ds_allowin), 64'd0);
    check("fullpop_count", 64'(iq_if.iq_count), 64'd4);
    tick;
    void'(exp_q.pop_front());
    check("fullpop_next_count", 64'(iq_if.iq_count), 64'd3);
    check("fullpop_next_allowin", 64'(iq_if.ds_allowin), 64'd1);
    check("fullpop_next_head", iq_if.iq_to_ds_bus, exp_q[0]);
    exp_q.push_back(pkt(32'h1c000410));
    drive(1, 32'h1c000410, 0, 0);
    tick;
    check("fullpop_refill_count", 64'(iq_if.iq_count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check_head("fullpop_drain");
      drive(0, 32'h0, 1, 0);
      tick;
    end
    check("final_count", 64'(iq_if.iq_count), 64'd0);
    check("final_queue_left", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
